// File: rtl/sprite_arb_pkg.sv
//============================================================================
// sprite_arb_pkg: shared defaults, types and helpers for sprite_rom_arbiter.
// Rev 1.0
//============================================================================
`default_nettype none

package sprite_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 3;
  localparam int DEF_ROM_LAT = 1;

  typedef logic [$clog2(DEF_N_REQ)-1:0] req_id_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
//============================================================================
// rr_picker: first asserted request at or after ptr, wrapping modulo N_REQ.
// Rev 1.0
//============================================================================
`default_nettype none

module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             found
);

  logic [ID_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
//============================================================================
// sprite_rom_arbiter: round-robin sharing of one sprite ROM with burst lock.
// Build option SPRITE_ARB_PRIO0_EN gives requester 0 absolute idle priority.
// Rev 1.0
//============================================================================
`default_nettype none

module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t      state, next_state;
  logic [ID_W-1:0] ptr, next_ptr;
  logic [ID_W-1:0] owner, next_owner;
  logic [ID_W-1:0] pick_id, grant_id;
  logic            pick_found, grant_vld;

  logic [ROM_LAT-1:0]           pipe_valid;
  logic [ROM_LAT-1:0][ID_W-1:0] pipe_id;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_id),
    .found  (pick_found)
  );

  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_owner = owner;
    grant_vld  = 1'b0;
    grant_id   = owner;
    gnt        = '0;
    rom_addr   = '0;
    case (state)
      IDLE: begin
`ifdef SPRITE_ARB_PRIO0_EN
        // Priority grants to requester 0 leave the rotation untouched.
        if (req[0]) begin
          grant_vld = 1'b1;
          grant_id  = '0;
        end else
`endif
        if (pick_found) begin
          grant_vld = 1'b1;
          grant_id  = pick_id;
          next_ptr  = ID_W'(wrap_inc(int'(pick_id), N_REQ));
        end
        if (grant_vld && lock[grant_id]) begin
          next_state = LOCKED;
          next_owner = grant_id;
        end
      end
      LOCKED: begin
        if (req[owner]) begin
          grant_vld = 1'b1;
          grant_id  = owner;
          if (!lock[owner]) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (!reset_n) grant_vld = 1'b0;
    if (grant_vld) begin
      gnt[grant_id] = 1'b1;
      rom_addr      = addr[int'(grant_id)*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
      owner <= next_owner;
    end
  end

  // Requester ids ride alongside the ROM latency so each result finds its owner.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid <= '0;
      pipe_id    <= '0;
      rd_valid   <= '0;
      rd_data    <= '0;
    end else begin
      pipe_valid[0] <= grant_vld;
      pipe_id[0]    <= grant_id;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
      rd_valid <= '0;
      if (pipe_valid[ROM_LAT-1]) begin
        rd_valid[pipe_id[ROM_LAT-1]] <= 1'b1;
        rd_data                      <= rom_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
//============================================================================
// tb_sprite_rom_arbiter: vector table, corner sequences and random traffic
// against a reference model, on ROM_LAT=1 and ROM_LAT=3 instances.
// Rev 1.0
//============================================================================
`default_nettype none

module tb_sprite_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 3;
  localparam int HN = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [N-1:0]    req, lock;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    gnt1, gnt3, rdv1, rdv3;
  logic [AW-1:0]   ra1, ra3;
  logic [DW-1:0]   q1, q3, rd1, rd3;
  logic [DW-1:0]   sr3 [3];

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_dut1 (
    .vga_clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .addr(addr),
    .gnt(gnt1), .rom_addr(ra1), .rom_q(q1), .rd_valid(rdv1), .rd_data(rd1));

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) u_dut3 (
    .vga_clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .addr(addr),
    .gnt(gnt3), .rom_addr(ra3), .rom_q(q3), .rd_valid(rdv3), .rd_data(rd3));

  // ROM contents: data = low address bits, delayed by the ROM latency.
  always @(posedge clk) begin
    q1     <= ra1[DW-1:0];
    sr3[0] <= ra3[DW-1:0];
    sr3[1] <= sr3[0];
    sr3[2] <= sr3[1];
  end
  assign q3 = sr3[2];

  int n_cmp = 0;
  int n_bad = 0;

  int            m_ptr = 0, m_owner = 0, cyc = 0, last_rst = -1;
  bit            m_locked = 1'b0;
  int            hist_id   [HN];
  logic [AW-1:0] hist_addr [HN];
  logic [DW-1:0] exp_rd1 = '0, exp_rd3 = '0;

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom;
    logic [N-1:0]    rdv;
    logic [DW-1:0]   rdd;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    if (m_locked) return r[m_owner] ? m_owner : -1;
`ifdef SPRITE_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int ret_src(input int lat);
    int src;
    src = cyc - lat - 1;
    if (src <= last_rst || src < 0) return -1;
    if (hist_id[src] < 0) return -1;
    return src;
  endfunction

  task automatic drive_check(input logic [N-1:0] r, input logic [N-1:0] l,
                             input logic [N*AW-1:0] a, output int w);
    logic [N-1:0]  eg, ev;
    logic [AW-1:0] ea;
    int            s;
    @(negedge clk);
    reset_n = 1'b1;
    req = r; lock = l; addr = a;
    #1;
    w = model_pick(r);
    eg = '0; ea = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ea    = a[w*AW +: AW];
    end
    hist_id[cyc]   = w;
    hist_addr[cyc] = ea;
    chk("gnt_lat1", 64'(gnt1), 64'(eg));
    chk("gnt_lat3", 64'(gnt3), 64'(eg));
    chk("rom_addr_lat1", 64'(ra1), 64'(ea));
    chk("rom_addr_lat3", 64'(ra3), 64'(ea));
    s = ret_src(1);
    ev = '0;
    if (s >= 0) begin ev[hist_id[s]] = 1'b1; exp_rd1 = hist_addr[s][DW-1:0]; end
    chk("rd_valid_lat1", 64'(rdv1), 64'(ev));
    chk("rd_data_lat1", 64'(rd1), 64'(exp_rd1));
    s = ret_src(3);
    ev = '0;
    if (s >= 0) begin ev[hist_id[s]] = 1'b1; exp_rd3 = hist_addr[s][DW-1:0]; end
    chk("rd_valid_lat3", 64'(rdv3), 64'(ev));
    chk("rd_data_lat3", 64'(rd3), 64'(exp_rd3));
  endtask

  task automatic tick(input int w, input logic [N-1:0] l);
    @(posedge clk);
    if (w >= 0) begin
      if (!m_locked) begin
`ifdef SPRITE_ARB_PRIO0_EN
        if (w != 0) m_ptr = (w + 1) % N;
`else
        m_ptr = (w + 1) % N;
`endif
        if (l[w]) begin m_locked = 1'b1; m_owner = w; end
      end else if (!l[w]) begin
        m_locked = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic run_cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*AW-1:0] a);
    int w;
    drive_check(r, l, a, w);
    tick(w, l);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n = 1'b0;
      req = '0; lock = '0;
      #1;
      m_ptr = 0; m_owner = 0; m_locked = 1'b0;
      exp_rd1 = '0; exp_rd3 = '0;
      hist_id[cyc] = -1;
      last_rst = cyc;
      chk("rst_gnt", 64'(gnt1 | gnt3), 64'(0));
      chk("rst_rom_addr", 64'(ra1 | ra3), 64'(0));
      chk("rst_rd_valid", 64'(rdv1 | rdv3), 64'(0));
      chk("rst_rd_data", 64'(rd1 | rd3), 64'(0));
      @(posedge clk);
      cyc++;
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*AW-1:0] a,
                              input logic [N-1:0] g, input logic [AW-1:0] ra,
                              input logic [N-1:0] v, input logic [DW-1:0] d);
    vec_t t;
    t.req = r; t.lock = l; t.addr = a; t.gnt = g; t.rom = ra; t.rdv = v; t.rdd = d;
    return t;
  endfunction

  initial begin
    int w;
    logic [N*AW-1:0] a;
    logic [N-1:0]    r, l, eg;

    tbl[0]  = mk(4'b0001, 4'b0000, {10'd0, 10'd0,  10'd0, 10'd5},  4'b0001, 10'd5,  4'b0000, 3'd0);
    tbl[1]  = mk(4'b0000, 4'b0000, '0,                             4'b0000, 10'd0,  4'b0000, 3'd0);
    tbl[2]  = mk(4'b0000, 4'b0000, '0,                             4'b0000, 10'd0,  4'b0001, 3'd5);
    tbl[3]  = mk(4'b0010, 4'b0000, {10'd0, 10'd0,  10'd7, 10'd0},  4'b0010, 10'd7,  4'b0000, 3'd5);
    tbl[4]  = mk(4'b1110, 4'b0100, {10'd3, 10'd2,  10'd1, 10'd0},  4'b0100, 10'd2,  4'b0000, 3'd5);
    tbl[5]  = mk(4'b1110, 4'b0100, {10'd3, 10'd10, 10'd1, 10'd0},  4'b0100, 10'd10, 4'b0010, 3'd7);
    tbl[6]  = mk(4'b1110, 4'b0000, {10'd3, 10'd12, 10'd1, 10'd0},  4'b0100, 10'd12, 4'b0100, 3'd2);
    tbl[7]  = mk(4'b1010, 4'b0000, {10'd3, 10'd0,  10'd1, 10'd0},  4'b1000, 10'd3,  4'b0100, 3'd2);
    tbl[8]  = mk(4'b1010, 4'b0000, {10'd3, 10'd0,  10'd9, 10'd0},  4'b0010, 10'd9,  4'b0100, 3'd4);
    tbl[9]  = mk(4'b0001, 4'b0001, {10'd0, 10'd0,  10'd0, 10'd20}, 4'b0001, 10'd20, 4'b1000, 3'd3);
    tbl[10] = mk(4'b1110, 4'b0000, {10'd1, 10'd2,  10'd3, 10'd21}, 4'b0000, 10'd0,  4'b0010, 3'd1);
    tbl[11] = mk(4'b1111, 4'b0000, {10'd1, 10'd2,  10'd3, 10'd22}, 4'b0001, 10'd22, 4'b0001, 3'd4);
    tbl[12] = mk(4'b0000, 4'b0000, '0,                             4'b0000, 10'd0,  4'b0000, 3'd4);

    reset_n = 1'b0; req = '0; lock = '0; addr = '0;
    do_reset(2);

    foreach (tbl[i]) begin
      drive_check(tbl[i].req, tbl[i].lock, tbl[i].addr, w);
      chk("tbl_gnt", 64'(gnt1), 64'(tbl[i].gnt));
      chk("tbl_rom_addr", 64'(ra1), 64'(tbl[i].rom));
      chk("tbl_rd_valid", 64'(rdv1), 64'(tbl[i].rdv));
      chk("tbl_rd_data", 64'(rd1), 64'(tbl[i].rdd));
      tick(w, tbl[i].lock);
    end
    for (int i = 0; i < 4; i++) run_cycle('0, '0, '0);

    // All four requesting: strict rotation from ptr=0.
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      a = {10'(i + 40), 10'(i + 30), 10'(i + 20), 10'(i + 10)};
      drive_check(4'b1111, 4'b0000, a, w);
      eg = '0;
`ifdef SPRITE_ARB_PRIO0_EN
      eg[0] = 1'b1;
`else
      eg[i % N] = 1'b1;
`endif
      chk("rr_order", 64'(gnt1), 64'(eg));
      tick(w, 4'b0000);
    end
    for (int i = 0; i < 5; i++) run_cycle('0, '0, '0);

    // Requesters 0 and 1 held together.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      drive_check(4'b0011, 4'b0000, {10'd0, 10'd0, 10'd6, 10'd5}, w);
`ifdef SPRITE_ARB_PRIO0_EN
      eg = 4'b0001;
`else
      eg = (i % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
      chk("pair_0_1", 64'(gnt1), 64'(eg));
      tick(w, 4'b0000);
    end
    for (int i = 0; i < 5; i++) run_cycle('0, '0, '0);

    // ROM_LAT=3: grants 1,3,0 back to back return on consecutive cycles.
    do_reset(1);
    run_cycle(4'b0010, 4'b0000, {10'd0, 10'd0, 10'd11, 10'd0});
    run_cycle(4'b1000, 4'b0000, {10'd13, 10'd0, 10'd0, 10'd0});
    run_cycle(4'b0001, 4'b0000, {10'd0, 10'd0, 10'd0, 10'd14});
    for (int j = 0; j < 6; j++) begin
      drive_check('0, '0, '0, w);
      eg = (j == 1) ? 4'b0010 : (j == 2) ? 4'b1000 : (j == 3) ? 4'b0001 : 4'b0000;
      chk("lat3_rd_valid", 64'(rdv3), 64'(eg));
      if (j >= 1 && j <= 3)
        chk("lat3_rd_data", 64'(rd3), 64'((j == 1) ? 3'd3 : (j == 2) ? 3'd5 : 3'd6));
      tick(w, '0);
    end

    // Reset mid-burst with reads in flight.
    do_reset(1);
    run_cycle(4'b0100, 4'b0100, {10'd0, 10'd1, 10'd0, 10'd0});
    run_cycle(4'b0110, 4'b0100, {10'd0, 10'd2, 10'd0, 10'd0});
    do_reset(1);
    for (int j = 0; j < 4; j++) begin
      drive_check('0, '0, '0, w);
      chk("flush_rd_valid", 64'(rdv1 | rdv3), 64'(0));
      tick(w, '0);
    end
    drive_check(4'b1100, 4'b0000, {10'd9, 10'd8, 10'd0, 10'd0}, w);
    chk("post_reset_gnt", 64'(gnt1), 64'(4'b0100));
    tick(w, '0);
    for (int i = 0; i < 5; i++) run_cycle('0, '0, '0);

    // Random traffic against the reference model.
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      a[31:0]  = $urandom;
      a[39:32] = 8'($urandom);
      run_cycle(r, l, a);
    end
    for (int i = 0; i < 5; i++) run_cycle('0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
